// File: rtl/alu_exec_pipe.sv
// Two-stage ALU execute pipeline: S1 holds the operands and control code, S2 holds
// the result and flags. Valid/ready on both sides with full backpressure.
module alu_exec_pipe #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal_op,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    logic             s1_valid_q, s1_valid_d;
    logic [3:0]       s1_ctrl_q;
    logic [WIDTH-1:0] s1_a_q, s1_b_q;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             overflow_q, overflow_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic             s2_free, s1_free, s1_move, accept, consume;
    logic [WIDTH-1:0] sum, diff;
    logic             slt;

    assign s2_free  = !s2_valid_q || out_ready;
    assign s1_move  = s1_valid_q && s2_free;
    assign s1_free  = !s1_valid_q || s2_free;
    assign accept   = in_valid && s1_free;
    assign consume  = s2_valid_q && out_ready;

    assign sum  = s1_a_q + s1_b_q;
    assign diff = s1_a_q - s1_b_q;
    // Differing signs decide the compare directly, so an overflowing a-b never matters.
    assign slt  = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) ? s1_a_q[WIDTH-1] : diff[WIDTH-1];

    always_comb begin
        result_d   = '0;
        overflow_d = 1'b0;
        illegal_d  = 1'b0;
        case (s1_ctrl_q)
            OP_ADD: begin
                result_d   = sum;
                overflow_d = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) &&
                             (sum[WIDTH-1] != s1_a_q[WIDTH-1]);
            end
            OP_SUB: begin
                result_d   = diff;
                overflow_d = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) &&
                             (diff[WIDTH-1] != s1_a_q[WIDTH-1]);
            end
            OP_AND:  result_d = s1_a_q & s1_b_q;
            OP_OR:   result_d = s1_a_q | s1_b_q;
            OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, slt};
            OP_NOR:  result_d = ~(s1_a_q | s1_b_q);
            default: illegal_d = 1'b1;
        endcase
        zero_d = (result_d == '0);
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        if (accept)
            s1_valid_d = 1'b1;
        else if (s1_move)
            s1_valid_d = 1'b0;

        s2_valid_d = s2_valid_q;
        if (s1_move)
            s2_valid_d = 1'b1;
        else if (out_ready)
            s2_valid_d = 1'b0;

        op_count_d = op_count_q;
        if (consume)
            op_count_d = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_ctrl_q  <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
            op_count_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            op_count_q <= op_count_d;
            if (accept) begin
                s1_ctrl_q <= alu_ctrl;
                s1_a_q    <= a;
                s1_b_q    <= b;
            end
            // S2 only loads on advance, so stalled outputs hold their value.
            if (s1_move) begin
                result_q   <= result_d;
                zero_q     <= zero_d;
                overflow_q <= overflow_d;
                illegal_q  <= illegal_d;
            end
        end
    end

    assign in_ready   = s1_free;
    assign out_valid  = s2_valid_q;
    assign result     = result_q;
    assign zero       = zero_q;
    assign overflow   = overflow_q;
    assign illegal_op = illegal_q;
    assign op_count   = op_count_q;

endmodule
